// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter.
// A word is taken over a valid/ready load handshake and shifted out one bit per
// accepted serial beat. A new word can be loaded in the cycle the last bit
// leaves, so consecutive words stream with no idle gap on the serial link.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [CW-1:0]    cnt, cnt_nx;

    // Next-state, next shift register / counter and handshake outputs.
    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        cnt_nx     = cnt;
        load_ready = 1'b0;
        sout_valid = 1'b0;
        sout       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    shreg_nx = data;
                    cnt_nx   = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                sout_valid = 1'b1;
                sout       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
                if (sout_ready) begin
                    if (cnt == LAST) begin
                        // Last bit leaves this cycle; the slot is free for a new word.
                        done       = 1'b1;
                        load_ready = 1'b1;
                        if (load_valid) begin
                            shreg_nx = data;
                            cnt_nx   = '0;
                        end else begin
                            state_nx = IDLE;
                            shreg_nx = '0;
                            cnt_nx   = '0;
                        end
                    end else begin
                        shreg_nx = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                             : {1'b0, shreg[WIDTH-1:1]};
                        cnt_nx   = cnt + CW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, shift register and bit counter; clear wins over everything.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            shreg <= shreg_nx;
            cnt   <= cnt_nx;
        end
    end

endmodule
